// File: rtl/r2r_pattern_seq.sv
`timescale 1ns/1ps
// r2r_pattern_seq: playback sequencer for the 256x8 R2R pattern RAM.
// While idle it forwards CPU pattern writes to the RAM write port. On a trigger
// it streams RAM entries 0..length to the R2R DAC. Each sample is held for
// period+1 clocks, and the whole pattern is played repeat_n+1 times.
module r2r_pattern_seq #(
  parameter logic [7:0] IDLE_CODE = 8'h00
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cfg_we,
  input  logic [7:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic [7:0] length,
  input  logic [7:0] period,
  input  logic [7:0] repeat_n,
  input  logic       trigger,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       cfg_err,
  output logic [7:0] r2r_out,
  output logic [7:0] ram_data,
  output logic [7:0] ram_wraddress,
  output logic       ram_wren,
  output logic [7:0] ram_rdaddress,
  input  logic [7:0] ram_q
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_PLAY
  } state_t;

  state_t     r_state;
  state_t     w_next_state;

  // Configuration captured at trigger time; live inputs are ignored afterwards.
  logic [7:0] r_len;
  logic [7:0] r_per;
  logic [7:0] r_rep;

  logic [7:0] r_samp;      // index of the sample loaded at the next slot edge
  logic [7:0] r_hold;      // clocks elapsed within the current sample slot
  logic [7:0] r_pass;      // passes completed so far
  logic       r_fin;       // last sample of the last pass is on the output
  logic [7:0] r_rdaddr;
  logic [7:0] r_r2r;
  logic       r_done;
  logic       r_cfg_err;
  logic       r_err_pend;

  logic       w_busy;
  logic       w_start;
  logic       w_abort;
  logic       w_load;
  logic       w_fetch;
  logic       w_finish;
  logic       w_reject;
  logic [7:0] w_next_addr;

  assign w_busy      = (r_state != S_IDLE);
  assign w_start     = (r_state == S_IDLE) && trigger && !abort;
  assign w_abort     = w_busy && abort;
  // A slot edge loads ram_q into the output.
  assign w_load      = (r_state == S_PLAY) && (r_hold == 8'd0);
  // The read address moves one edge ahead of each slot edge to cover the
  // RAM latency. The first such edge is the PRIME->PLAY edge.
  assign w_fetch     = (r_state == S_PRIME) ||
                       ((r_state == S_PLAY) && (r_hold == r_per));
  assign w_finish    = w_load && r_fin && !abort;
  assign w_reject    = cfg_we && w_busy;
  assign w_next_addr = (r_rdaddr == r_len) ? 8'd0 : r_rdaddr + 8'd1;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; abort takes priority over start and completion.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next_state = S_PRIME;
        end
      end
      S_PRIME: begin
        if (abort) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_PLAY;
        end
      end
      S_PLAY: begin
        if (abort || w_finish) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode from state and registered flags; the write port is a pass-through.
  always_comb begin
    busy          = w_busy;
    done          = r_done;
    cfg_err       = r_cfg_err;
    r2r_out       = r2r_out_q();
    ram_rdaddress = r_rdaddr;
    ram_wraddress = cfg_addr;
    ram_data      = cfg_data;
    ram_wren      = cfg_we && !w_busy;
  end

  function automatic logic [7:0] r2r_out_q();
    return r_r2r;
  endfunction

  // Shadow configuration, slot/sample/pass counters and read address.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_len    <= '0;
      r_per    <= '0;
      r_rep    <= '0;
      r_samp   <= '0;
      r_hold   <= '0;
      r_pass   <= '0;
      r_fin    <= 1'b0;
      r_rdaddr <= '0;
    end else if (w_start) begin
      r_len    <= length;
      r_per    <= period;
      r_rep    <= repeat_n;
      r_samp   <= '0;
      r_hold   <= '0;
      r_pass   <= '0;
      r_fin    <= 1'b0;
      r_rdaddr <= '0;
    end else if (w_abort || w_finish) begin
      r_samp   <= '0;
      r_hold   <= '0;
      r_pass   <= '0;
      r_fin    <= 1'b0;
      r_rdaddr <= '0;
    end else if (w_busy) begin
      if (w_fetch) begin
        r_rdaddr <= w_next_addr;
      end
      if (r_state == S_PLAY) begin
        r_hold <= (r_hold == r_per) ? 8'd0 : r_hold + 8'd1;
        if (w_load) begin
          if (r_samp == r_len) begin
            r_samp <= '0;
            if (r_pass == r_rep) begin
              r_fin <= 1'b1;
            end else begin
              r_pass <= r_pass + 8'd1;
            end
          end else begin
            r_samp <= r_samp + 8'd1;
          end
        end
      end
    end
  end

  // DAC output register plus the done / cfg_err pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_r2r      <= IDLE_CODE;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_err_pend <= 1'b0;
    end else begin
      if (w_abort || w_finish) begin
        r_r2r <= IDLE_CODE;
      end else if (w_load) begin
        r_r2r <= ram_q;
      end
      r_done <= w_finish;
      // A write rejected on the completion edge would collide with done, so
      // its error pulse is deferred by one cycle; busy is low by then, so no
      // new rejection can coincide with the deferred one.
      r_cfg_err  <= (w_reject && !w_finish) || r_err_pend;
      r_err_pend <= w_reject && w_finish;
    end
  end

endmodule

// File: doc/r2r_pattern_seq.md
# r2r_pattern_seq

Playback sequencer for the 256x8 R2R pattern RAM (`R2Rram`) in domapp. Owns both RAM ports. While idle it lets the CPU-side register interface load pattern bytes. On trigger it streams RAM contents from address 0 through `length` to the R2R ladder DAC, holding each sample for a programmable number of clocks and repeating the pattern a programmable number of times.

## Interface
- `IDLE_CODE`, 8'h00, value driven on `r2r_out` whenever no pattern is playing.
- `clock` in 1: single system clock. RAM shares it.
- `reset_n` in 1: asynchronous, active-low reset.
- `cfg_we` in 1: pattern-byte write strobe.
- `cfg_addr` in 8: pattern write address.
- `cfg_data` in 8: pattern write data.
- `length` in 8: index of last sample; plays `length`+1 samples.
- `period` in 8: clocks per sample minus 1.
- `repeat_n` in 8: extra passes; 0 means play once.
- `trigger` in 1: start playback; level-sampled.
- `abort` in 1: stop playback.
- `busy` out 1: playback in progress.
- `done` out 1: 1-cycle pulse on normal completion.
- `cfg_err` out 1: 1-cycle pulse when a write is rejected.
- `r2r_out` out 8: DAC sample, registered.
- `ram_data` out 8: to `R2Rram.data`.
- `ram_wraddress` out 8: to `R2Rram.wraddress`.
- `ram_wren` out 1: to `R2Rram.wren`.
- `ram_rdaddress` out 8: to `R2Rram.rdaddress`.
- `ram_q` in 8: from `R2Rram.q`. The RAM latches `rdaddress` on the clock edge; `q` is valid after that edge.

## Operation
- The FSM has three states: IDLE, PRIME and PLAY.
- **Reset values:** state IDLE; `busy`, `done`, `cfg_err`, `ram_wren` = 0; `r2r_out` = IDLE_CODE; `ram_rdaddress` = 0; all counters = 0.
- **Write path:**
  - `ram_wren` = `cfg_we` & !`busy` (combinational).
  - `ram_wraddress` = `cfg_addr`, `ram_data` = `cfg_data`.
  - `cfg_we` while `busy` is high gives `ram_wren` = 0 and a registered `cfg_err` pulse on the next edge.
- **IDLE:**
  - `trigger` high and `abort` low at an edge latches `length`, `period` and `repeat_n` into internal shadow registers, sets the sample, hold and pass counters to 0, and moves to PRIME.
  - If `trigger` and `abort` are both high, `abort` wins and the block stays in IDLE.
- **PRIME:** lasts one clock to cover the RAM read latency, then moves to PLAY.
- **PLAY, addressing:** `ram_rdaddress` leads the output by the RAM latency, so each new sample is loaded from `ram_q` exactly on its slot edge with no bubbles.
- **PLAY, sample slots:** each sample occupies `period`+1 clocks.
- **PLAY, end of a pass:** after sample `length`:
  - If passes remaining > 0, wrap to address 0 with no gap and decrement passes.
  - Otherwise, at the end of the last slot, set `r2r_out` to IDLE_CODE, pulse `done`, drop `busy` and return to IDLE, all on the same edge.
- **Pointer width:** the sample pointer is 8 bits. `length`=255 plays all 256 entries; the wrap from 255 to 0 is only taken on a repeat.
- **`length`=0:** a single sample, repeated `repeat_n`+1 times.
- **Abort:** `abort` in PRIME or PLAY returns the block to IDLE on the next edge. `r2r_out` goes to IDLE_CODE and `busy` to 0; there is no `done` pulse.
- **Trigger while busy:** ignored, not queued.
- **Input changes during playback:** changes to `length`, `period` or `repeat_n` have no effect.
- **Reset mid-operation:** asserting `reset_n` low forces all reset values immediately (asynchronously).

## Timing
- Let E0 be the edge at which `trigger` is accepted.
- `busy` is high from E0 until the completion edge.
- Sample k of pass p appears on `r2r_out` at edge E2 + (p·(L+1) + k)·(P+1), where L=`length` and P=`period`.
- The completion edge, where `done` is high for one cycle, is E2 + (L+1)(P+1)(R+1), where R=`repeat_n`.
- A new trigger is accepted at the completion edge + 1 at the earliest.
- `cfg_err` and `done` are registered and never asserted together.

## Test plan
1. **Basic play:** load mem[0..3]=10,20,30,40; set L=3, P=0, R=0; trigger.
   - Expect `r2r_out` = 10,20,30,40 at E2..E5.
   - At E6, `r2r_out`=0x00 and `done`=1; `busy` is high from E0 to E6.
2. **Sample hold:** same pattern with P=2.
   - Each value is held 3 clocks (10 at E2–E4, 20 at E5–E7, and so on).
   - `done` at E14.
3. **Repeat with no gap:** load mem[0]=0xAA, mem[1]=0x55; set L=1, P=0, R=2.
   - Expect AA,55,AA,55,AA,55 at E2..E7 with no gaps.
   - `done` at E8.
4. **Abort and retrigger:**
   - Abort at E4 of scenario 1: at E5, `r2r_out`=0x00 and `busy`=0; no `done` ever.
   - A subsequent trigger replays from 10.
5. **Rejected write, late inputs, ignored trigger:**
   - `cfg_we` to address 1 with 0xFF during playback gives `ram_wren`=0 and a `cfg_err` pulse.
   - Changing `length` mid-play and retriggering while busy have no effect.
   - A replay still outputs 20 at address 1.
6. **Full pattern and async reset:**
   - L=255, P=0, R=1 with mem[i]=i: expect 0..255,0..255 contiguous, and `done` at E514.
   - `reset_n` pulsed low mid-play: all outputs reach their reset values with no clock edge.
